mo_mem_ctrl: RTL and testbench
==============================

MO_MEM_CTRL -- requirements
Module: mo_mem_ctrl

Interface
REQ-001 Parameter MAXN, default 8: maximum matrix dimension; A, X, B and Y storage is MAXN x MAXN.
REQ-002 Parameter TIMEOUT, default 100000: maximum SERVE cycles without fin.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 load_valid  in  1  host load strobe.
REQ-006 load_sel  in  3  load target: 0=N, 1=R, 2=A, 3=X, 4=B; 5-7 ignored.
REQ-007 load_i, load_j  in  10 each  element row and column; ignored for N and R.
REQ-008 load_data  in  10  value to store.
REQ-009 load_ready  out  1  high only in IDLE.
REQ-010 start  in  1  begin a compute run.
REQ-011 clear  in  1  leave DONE and return to IDLE.
REQ-012 mo_reset_n  out  1  active-low reset to the matrix engine.
REQ-013 opcode  in  3  engine request: 7=INIT, 0=GET_N, 1=GET_R, 2=READ_A, 3=READ_X, 4=READ_B, 5=WRITE_Y.
REQ-014 i, j  in  10 each  engine element address.
REQ-015 out_data  in  20  engine result (Y element).
REQ-016 fin  in  1  engine completion flag.
REQ-017 in_data  out  10  data returned to the engine.
REQ-018 y_rd_en  in  1  readback request.
REQ-019 y_rd_i, y_rd_j  in  10 each  readback address.
REQ-020 y_rd_data  out  20  readback data.
REQ-021 y_rd_valid  out  1  readback data valid.
REQ-022 done  out  1  high in DONE.
REQ-023 timeout  out  1  run ended by timeout.
REQ-024 err_oob  out  1  sticky address/configuration error.
REQ-025 y_count  out  10  number of accepted Y writes in the current run.

Function
REQ-026 FSM states: IDLE, SERVE, DONE.
REQ-027 IDLE: accept a load when load_valid is high; the stored element is overwritten on that edge.
REQ-028 IDLE: start with 1<=N<=MAXN -> SERVE; start with N=0 or N>MAXN -> DONE and set err_oob.
REQ-029 Simultaneous load_valid and start in IDLE: the load is performed and the state transition is taken on the same edge.
REQ-030 mo_reset_n is registered: 1 only while in SERVE (first 1 in the cycle after start is accepted), 0 otherwise.
REQ-031 Entering SERVE clears y_count, the cycle counter, timeout, err_oob and every Y valid bit.
REQ-032 in_data is combinational from opcode, i and j, with zero latency:
  - GET_N -> N; GET_R -> R.
  - READ_A / READ_X / READ_B -> A[i][j] / X[i][j] / B[i][j].
  - Any other opcode -> 0.
  - Outside SERVE -> 0.
REQ-033 In SERVE, an element access with i>=N or j>=N returns 0 and sets err_oob, except in a cycle where fin=1 (no flag is set).
REQ-034 In SERVE, opcode=WRITE_Y with in-bounds i, j writes out_data to Y[i][j], sets its valid bit and increments y_count (saturating at 1023); out-of-bounds writes are dropped and set err_oob.
REQ-035 In SERVE, fin=1 -> DONE on the next edge.
REQ-036 Otherwise, when the cycle counter reaches TIMEOUT -> DONE with timeout=1.
REQ-037 If fin and timeout occur in the same cycle, fin wins and timeout=0.
REQ-038 fin, opcode and WRITE_Y are ignored outside SERVE.
REQ-039 DONE: done=1; clear -> IDLE; start -> SERVE, applying the REQ-028 check.
REQ-040 If clear and start are both high in DONE, start wins.
REQ-041 Readback is honoured only in DONE, with 1-cycle latency: y_rd_en at edge t gives y_rd_valid=1 and y_rd_data at t+1.
  - Data is Y[i][j] if the address is in range and its valid bit is set; otherwise 0.
  - When no readback is in progress, y_rd_valid=0.
REQ-042 A, X and B contents persist across runs and are not cleared by reset.

Reset
REQ-043 When reset is high, on the next edge the block enters IDLE (including mid-SERVE) and takes these values:
  - mo_reset_n=0, load_ready=1, done=0, timeout=0, err_oob=0.
  - y_count=0, y_rd_valid=0, y_rd_data=0.
  - N=0, R=0, all Y valid bits cleared.
REQ-044 reset has priority over start, clear, load_valid and fin.

Verification
REQ-045 Load N=2, R=1, A=[[1,2],[3,4]], X=identity, B=[[10,20],[30,40]]; start; run a reference engine to fin -> done=1; y_count=4; readback Y = 11,22,33,44; err_oob=0.
REQ-046 In SERVE, drive opcode=READ_A, i=0, j=1 -> in_data=2 in the same cycle; opcode=GET_R -> in_data=1.
REQ-047 In SERVE with N=2, drive opcode=READ_X, i=2 -> in_data=0 and err_oob=1; repeat with fin=1 -> err_oob stays 0.
REQ-048 Start with N=0 -> DONE next edge, err_oob=1, mo_reset_n never 1.
REQ-049 TIMEOUT=16, engine never asserts fin -> DONE after 16 SERVE cycles, timeout=1; fin and timeout in the same cycle -> timeout=0.
REQ-050 Assert reset mid-SERVE after 2 Y writes -> next edge IDLE, y_count=0, mo_reset_n=0; A contents unchanged on the next run.

Source files
------------

// File: rtl/mo_mem_ctrl_if.sv
// Bus bundle between the matrix memory controller, its host loader and the matrix engine.
// All signals are sampled on the controller clock; the controller side uses the slave modport.
interface mo_mem_ctrl_if;
    logic        load_valid;
    logic [2:0]  load_sel;
    logic [9:0]  load_i;
    logic [9:0]  load_j;
    logic [9:0]  load_data;
    logic        load_ready;
    logic        start;
    logic        clear;
    logic        mo_reset_n;
    logic [2:0]  opcode;
    logic [9:0]  i;
    logic [9:0]  j;
    logic [19:0] out_data;
    logic        fin;
    logic [9:0]  in_data;
    logic        y_rd_en;
    logic [9:0]  y_rd_i;
    logic [9:0]  y_rd_j;
    logic [19:0] y_rd_data;
    logic        y_rd_valid;
    logic        done;
    logic        timeout;
    logic        err_oob;
    logic [9:0]  y_count;

    modport slave (
        input  load_valid, load_sel, load_i, load_j, load_data,
        input  start, clear, opcode, i, j, out_data, fin,
        input  y_rd_en, y_rd_i, y_rd_j,
        output load_ready, mo_reset_n, in_data, y_rd_data, y_rd_valid,
        output done, timeout, err_oob, y_count
    );

    modport master (
        output load_valid, load_sel, load_i, load_j, load_data,
        output start, clear, opcode, i, j, out_data, fin,
        output y_rd_en, y_rd_i, y_rd_j,
        input  load_ready, mo_reset_n, in_data, y_rd_data, y_rd_valid,
        input  done, timeout, err_oob, y_count
    );
endinterface

// File: rtl/mo_mem_ctrl.sv
// Memory controller serving A/X/B operands to a matrix engine and capturing its Y results.
// Host loads in IDLE, engine runs in SERVE, results are read back in DONE.
module mo_mem_ctrl #(
    parameter int MAXN    = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic         clk,
    input  logic         reset,
    mo_mem_ctrl_if.slave io_bus,
    output logic [1:0]   o_state
);
    localparam int          IW      = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [9:0]  MAXN_W  = 10'(MAXN);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    localparam logic [2:0] OP_GET_N   = 3'd0;
    localparam logic [2:0] OP_GET_R   = 3'd1;
    localparam logic [2:0] OP_READ_A  = 3'd2;
    localparam logic [2:0] OP_READ_X  = 3'd3;
    localparam logic [2:0] OP_READ_B  = 3'd4;
    localparam logic [2:0] OP_WRITE_Y = 3'd5;

    localparam logic [2:0] LD_N = 3'd0;
    localparam logic [2:0] LD_R = 3'd1;
    localparam logic [2:0] LD_A = 3'd2;
    localparam logic [2:0] LD_X = 3'd3;
    localparam logic [2:0] LD_B = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [9:0]  r_n;
    logic [9:0]  r_r;
    logic [9:0]  r_a [MAXN][MAXN];
    logic [9:0]  r_x [MAXN][MAXN];
    logic [9:0]  r_b [MAXN][MAXN];
    logic [19:0] r_y [MAXN][MAXN];
    logic [MAXN-1:0][MAXN-1:0] r_yv;

    logic        r_mo_rst_n;
    logic [9:0]  r_y_count;
    logic [31:0] r_cyc;
    logic        r_timeout;
    logic        r_err;
    logic        r_rd_valid;
    logic [19:0] r_rd_data;

    logic          w_serve;
    logic          w_n_ok;
    logic          w_cfg_err;
    logic          w_to_hit;
    logic          w_enter_serve;
    logic          w_load_fire;
    logic          w_ld_in_arr;
    logic          w_is_elem;
    logic          w_in_rng;
    logic          w_oob_hit;
    logic          w_y_wr;
    logic          w_rd_in_arr;
    logic [IW-1:0] w_ei;
    logic [IW-1:0] w_ej;
    logic [IW-1:0] w_li;
    logic [IW-1:0] w_lj;
    logic [IW-1:0] w_ri;
    logic [IW-1:0] w_rj;
    logic [9:0]    w_in_data;

    assign w_serve     = (r_state == S_SERVE);
    assign w_n_ok      = (r_n != 10'd0) && (r_n <= MAXN_W);
    assign w_load_fire = (r_state == S_IDLE) && io_bus.load_valid;
    assign w_ld_in_arr = (io_bus.load_i < MAXN_W) && (io_bus.load_j < MAXN_W);
    assign w_rd_in_arr = (io_bus.y_rd_i < MAXN_W) && (io_bus.y_rd_j < MAXN_W);

    assign w_ei = io_bus.i[IW-1:0];
    assign w_ej = io_bus.j[IW-1:0];
    assign w_li = io_bus.load_i[IW-1:0];
    assign w_lj = io_bus.load_j[IW-1:0];
    assign w_ri = io_bus.y_rd_i[IW-1:0];
    assign w_rj = io_bus.y_rd_j[IW-1:0];

    // Element range check against the run's N; the MAXN terms keep array indices legal.
    assign w_is_elem = (io_bus.opcode >= OP_READ_A) && (io_bus.opcode <= OP_WRITE_Y);
    assign w_in_rng  = (io_bus.i < r_n) && (io_bus.j < r_n) &&
                       (io_bus.i < MAXN_W) && (io_bus.j < MAXN_W);
    assign w_oob_hit = w_serve && w_is_elem && !w_in_rng && !io_bus.fin;
    assign w_y_wr    = w_serve && (io_bus.opcode == OP_WRITE_Y) && w_in_rng;

    always_comb begin
        w_state_next = r_state;
        w_cfg_err    = 1'b0;
        w_to_hit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_state_next = w_n_ok ? S_SERVE : S_DONE;
                    w_cfg_err    = !w_n_ok;
                end
            end
            S_SERVE: begin
                // fin takes precedence, so a fin in the last budgeted cycle is not a timeout.
                if (io_bus.fin) begin
                    w_state_next = S_DONE;
                end else if (r_cyc == TO_LAST) begin
                    w_state_next = S_DONE;
                    w_to_hit     = 1'b1;
                end
            end
            S_DONE: begin
                if (io_bus.start) begin
                    w_state_next = w_n_ok ? S_SERVE : S_DONE;
                    w_cfg_err    = !w_n_ok;
                end else if (io_bus.clear) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_enter_serve = (w_state_next == S_SERVE) && !w_serve;

    always_comb begin
        w_in_data = 10'd0;
        if (w_serve) begin
            case (io_bus.opcode)
                OP_GET_N:  w_in_data = r_n;
                OP_GET_R:  w_in_data = r_r;
                OP_READ_A: if (w_in_rng) w_in_data = r_a[w_ei][w_ej];
                OP_READ_X: if (w_in_rng) w_in_data = r_x[w_ei][w_ej];
                OP_READ_B: if (w_in_rng) w_in_data = r_b[w_ei][w_ej];
                default:   w_in_data = 10'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_n        <= 10'd0;
            r_r        <= 10'd0;
            r_mo_rst_n <= 1'b0;
            r_y_count  <= 10'd0;
            r_cyc      <= 32'd0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
            r_yv       <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 20'd0;
        end else begin
            r_state    <= w_state_next;
            r_mo_rst_n <= (w_state_next == S_SERVE);

            if (w_load_fire) begin
                if (io_bus.load_sel == LD_N) begin
                    r_n <= io_bus.load_data;
                end else if (io_bus.load_sel == LD_R) begin
                    r_r <= io_bus.load_data;
                end
            end

            if (w_enter_serve) begin
                r_y_count <= 10'd0;
                r_cyc     <= 32'd0;
                r_timeout <= 1'b0;
                r_err     <= 1'b0;
                r_yv      <= '0;
            end else begin
                if (w_serve) begin
                    r_cyc <= r_cyc + 32'd1;
                end
                if (w_to_hit) begin
                    r_timeout <= 1'b1;
                end
                if (w_cfg_err || w_oob_hit) begin
                    r_err <= 1'b1;
                end
                if (w_y_wr) begin
                    r_yv[w_ei][w_ej] <= 1'b1;
                    if (r_y_count != 10'h3FF) begin
                        r_y_count <= r_y_count + 10'd1;
                    end
                end
            end

            if ((r_state == S_DONE) && io_bus.y_rd_en) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= (w_rd_in_arr && r_yv[w_ri][w_rj]) ? r_y[w_ri][w_rj] : 20'd0;
            end else begin
                r_rd_valid <= 1'b0;
                r_rd_data  <= 20'd0;
            end
        end
    end

    // Operand and result storage carry no reset: contents survive reset and later runs.
    always_ff @(posedge clk) begin
        if (w_load_fire && w_ld_in_arr) begin
            case (io_bus.load_sel)
                LD_A:    r_a[w_li][w_lj] <= io_bus.load_data;
                LD_X:    r_x[w_li][w_lj] <= io_bus.load_data;
                LD_B:    r_b[w_li][w_lj] <= io_bus.load_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_y_wr) begin
            r_y[w_ei][w_ej] <= io_bus.out_data;
        end
    end

    assign io_bus.load_ready = (r_state == S_IDLE);
    assign io_bus.done       = (r_state == S_DONE);
    assign io_bus.mo_reset_n = r_mo_rst_n;
    assign io_bus.in_data    = w_in_data;
    assign io_bus.y_rd_valid = r_rd_valid;
    assign io_bus.y_rd_data  = r_rd_data;
    assign io_bus.timeout    = r_timeout;
    assign io_bus.err_oob    = r_err;
    assign io_bus.y_count    = r_y_count;
    assign o_state           = r_state;
endmodule

// File: tb/tb_mo_mem_ctrl.sv
// Directed and randomized bench for mo_mem_ctrl; a behavioural engine computes Y = A*X + R*B
// and every readback is compared against values computed from the bench's own copies of A/X/B.
module tb_mo_mem_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mo_mem_ctrl_if b0();
    mo_mem_ctrl_if b1();
    logic [1:0] st0;
    logic [1:0] st1;

    mo_mem_ctrl #(.MAXN(8)) u_dut (
        .clk(clk), .reset(reset), .io_bus(b0), .o_state(st0)
    );
    mo_mem_ctrl #(.MAXN(8), .TIMEOUT(16)) u_to (
        .clk(clk), .reset(reset), .io_bus(b1), .o_state(st1)
    );

    int ma [8][8];
    int mx [8][8];
    int mb [8][8];
    int mn = 0;
    int mr = 0;
    logic [19:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load0(input int sel, input int li, input int lj, input int d);
        b0.load_valid = 1'b1;
        b0.load_sel   = 3'(sel);
        b0.load_i     = 10'(li);
        b0.load_j     = 10'(lj);
        b0.load_data  = 10'(d);
        case (sel)
            0: mn = d;
            1: mr = d;
            2: ma[li][lj] = d;
            3: mx[li][lj] = d;
            4: mb[li][lj] = d;
            default: ;
        endcase
        tick();
        b0.load_valid = 1'b0;
    endtask

    function automatic logic [19:0] yref(input int yi, input int yj);
        int s = 0;
        for (int k = 0; k < mn; k++) s += ma[yi][k] * mx[k][yj];
        s += mr * mb[yi][yj];
        return 20'(s);
    endfunction

    // Plays the matrix engine: fetches operands through in_data, writes every Y element.
    task automatic engine_run(input bit do_fin);
        int n;
        int r;
        int a;
        int x;
        int acc;
        b0.opcode = 3'd0;
        #1;
        n = int'(b0.in_data);
        chk("get_n", b0.in_data, mn);
        tick();
        b0.opcode = 3'd1;
        #1;
        r = int'(b0.in_data);
        chk("get_r", b0.in_data, mr);
        tick();
        if (n > 8) n = 8;
        for (int ii = 0; ii < n; ii++) begin
            for (int jj = 0; jj < n; jj++) begin
                acc = 0;
                for (int k = 0; k < n; k++) begin
                    b0.opcode = 3'd2; b0.i = 10'(ii); b0.j = 10'(k);
                    #1; a = int'(b0.in_data); tick();
                    b0.opcode = 3'd3; b0.i = 10'(k); b0.j = 10'(jj);
                    #1; x = int'(b0.in_data); tick();
                    acc += a * x;
                end
                b0.opcode = 3'd4; b0.i = 10'(ii); b0.j = 10'(jj);
                #1; acc += r * int'(b0.in_data); tick();
                b0.opcode = 3'd5; b0.out_data = 20'(acc);
                tick();
            end
        end
        b0.opcode = 3'd6;
        if (do_fin) begin
            b0.fin = 1'b1;
            tick();
            b0.fin = 1'b0;
        end
    endtask

    task automatic rb(input int ri, input int rj, input logic [19:0] e);
        b0.y_rd_en = 1'b1;
        b0.y_rd_i  = 10'(ri);
        b0.y_rd_j  = 10'(rj);
        exp_q.push_back(e);
        tick();
        b0.y_rd_en = 1'b0;
        chk($sformatf("rd_valid(%0d,%0d)", ri, rj), b0.y_rd_valid, 1);
        chk($sformatf("rd_data(%0d,%0d)", ri, rj), b0.y_rd_data, exp_q.pop_front());
    endtask

    task automatic pulse_start0();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
    endtask

    task automatic pulse_clear0();
        b0.clear = 1'b1;
        tick();
        b0.clear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;
        b0.load_valid = 0; b0.load_sel = 0; b0.load_i = 0; b0.load_j = 0; b0.load_data = 0;
        b0.start = 0; b0.clear = 0; b0.opcode = 3'd6; b0.i = 0; b0.j = 0;
        b0.out_data = 0; b0.fin = 0; b0.y_rd_en = 0; b0.y_rd_i = 0; b0.y_rd_j = 0;
        b1.load_valid = 0; b1.load_sel = 0; b1.load_i = 0; b1.load_j = 0; b1.load_data = 0;
        b1.start = 0; b1.clear = 0; b1.opcode = 3'd6; b1.i = 0; b1.j = 0;
        b1.out_data = 0; b1.fin = 0; b1.y_rd_en = 0; b1.y_rd_i = 0; b1.y_rd_j = 0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_load_ready", b0.load_ready, 1);
        chk("rst_done", b0.done, 0);
        chk("rst_mo_reset_n", b0.mo_reset_n, 0);
        chk("rst_timeout", b0.timeout, 0);
        chk("rst_err_oob", b0.err_oob, 0);
        chk("rst_y_count", b0.y_count, 0);
        chk("rst_rd_valid", b0.y_rd_valid, 0);
        chk("rst_rd_data", b0.y_rd_data, 0);
        b0.opcode = 3'd0;
        #1;
        chk("idle_in_data", b0.in_data, 0);

        // Directed 2x2 run: Y = A*I + 1*B
        load0(0, 0, 0, 2);
        load0(1, 0, 0, 1);
        load0(2, 0, 0, 1); load0(2, 0, 1, 2); load0(2, 1, 0, 3); load0(2, 1, 1, 4);
        load0(3, 0, 0, 1); load0(3, 0, 1, 0); load0(3, 1, 0, 0); load0(3, 1, 1, 1);
        load0(4, 0, 0, 10); load0(4, 0, 1, 20); load0(4, 1, 0, 30); load0(4, 1, 1, 40);
        pulse_start0();
        chk("serve_mo_reset_n", b0.mo_reset_n, 1);
        chk("serve_load_ready", b0.load_ready, 0);
        b0.opcode = 3'd2; b0.i = 10'd0; b0.j = 10'd1;
        #1;
        chk("read_a01", b0.in_data, 2);
        b0.opcode = 3'd1;
        #1;
        chk("get_r_direct", b0.in_data, 1);
        engine_run(1);
        chk("dir_done", b0.done, 1);
        chk("dir_y_count", b0.y_count, 4);
        chk("dir_err_oob", b0.err_oob, 0);
        chk("dir_mo_reset_n", b0.mo_reset_n, 0);
        rb(0, 0, 20'd11); rb(0, 1, 20'd22); rb(1, 0, 20'd33); rb(1, 1, 20'd44);
        rb(2, 0, 20'd0);
        tick();
        chk("rd_valid_idle", b0.y_rd_valid, 0);

        // Out-of-bounds access, with and without fin
        pulse_clear0();
        chk("clear_load_ready", b0.load_ready, 1);
        pulse_start0();
        b0.opcode = 3'd3; b0.i = 10'd2; b0.j = 10'd0; b0.fin = 1'b1;
        #1;
        chk("oob_fin_in_data", b0.in_data, 0);
        tick();
        b0.fin = 1'b0;
        chk("oob_fin_done", b0.done, 1);
        chk("oob_fin_err", b0.err_oob, 0);
        b0.clear = 1'b1;
        pulse_start0();
        b0.clear = 1'b0;
        chk("start_over_clear", b0.done, 0);
        b0.opcode = 3'd3; b0.i = 10'd2; b0.j = 10'd0;
        #1;
        chk("oob_in_data", b0.in_data, 0);
        tick();
        chk("oob_err", b0.err_oob, 1);
        b0.opcode = 3'd5; b0.i = 10'd0; b0.j = 10'd5; b0.out_data = 20'd77;
        tick();
        chk("oob_write_dropped", b0.y_count, 0);
        b0.opcode = 3'd6; b0.fin = 1'b1;
        tick();
        b0.fin = 1'b0;
        chk("oob_err_sticky", b0.err_oob, 1);
        rb(0, 0, 20'd0);

        // y_count saturation
        pulse_start0();
        b0.opcode = 3'd5; b0.i = 10'd0; b0.j = 10'd0; b0.out_data = 20'd123;
        repeat (1030) tick();
        chk("y_count_sat", b0.y_count, 1023);
        b0.opcode = 3'd6; b0.fin = 1'b1;
        tick();
        b0.fin = 1'b0;
        rb(0, 0, 20'd123);
        pulse_clear0();

        // Randomized runs against the reference model
        for (int fi = 0; fi < 8; fi++) begin
            for (int fj = 0; fj < 8; fj++) begin
                load0(2, fi, fj, $urandom_range(0, 15));
                load0(3, fi, fj, $urandom_range(0, 15));
                load0(4, fi, fj, $urandom_range(0, 15));
            end
        end
        for (int run = 0; run < 3; run++) begin
            n = $urandom_range(1, 8);
            load0(0, 0, 0, n);
            repeat (6) load0($urandom_range(2, 4), $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 15));
            b0.load_valid = 1'b1; b0.load_sel = 3'd1;
            b0.load_data  = 10'($urandom_range(0, 3));
            mr = int'(b0.load_data);
            pulse_start0();
            b0.load_valid = 1'b0;
            chk("rand_mo_reset_n", b0.mo_reset_n, 1);
            engine_run(1);
            chk("rand_done", b0.done, 1);
            chk("rand_y_count", b0.y_count, n * n);
            chk("rand_err_oob", b0.err_oob, 0);
            chk("rand_timeout", b0.timeout, 0);
            for (int ri = 0; ri < 8; ri++) begin
                for (int rj = 0; rj < 8; rj++) begin
                    rb(ri, rj, (ri < n && rj < n) ? yref(ri, rj) : 20'd0);
                end
            end
            rb(9, 0, 20'd0);
            pulse_clear0();
        end

        // Bad N: zero after reset, then above MAXN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mn = 0;
        mr = 0;
        pulse_start0();
        chk("n0_done", b0.done, 1);
        chk("n0_err", b0.err_oob, 1);
        chk("n0_mo_reset_n", b0.mo_reset_n, 0);
        b0.opcode = 3'd0;
        #1;
        chk("done_in_data", b0.in_data, 0);
        tick();
        chk("n0_mo_reset_n_hold", b0.mo_reset_n, 0);
        pulse_clear0();
        load0(0, 0, 0, 9);
        pulse_start0();
        chk("n9_done", b0.done, 1);
        chk("n9_err", b0.err_oob, 1);
        pulse_clear0();

        // Reset in the middle of a run; A/X/B must survive it
        load0(0, 0, 0, 2);
        load0(1, 0, 0, 1);
        pulse_start0();
        b0.opcode = 3'd5; b0.i = 10'd0; b0.j = 10'd0; b0.out_data = 20'd5;
        tick();
        b0.j = 10'd1;
        tick();
        b0.opcode = 3'd6;
        chk("mid_y_count", b0.y_count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mn = 0;
        mr = 0;
        chk("mid_load_ready", b0.load_ready, 1);
        chk("mid_y_count_rst", b0.y_count, 0);
        chk("mid_mo_reset_n", b0.mo_reset_n, 0);
        chk("mid_done", b0.done, 0);
        load0(0, 0, 0, 2);
        load0(1, 0, 0, 1);
        pulse_start0();
        engine_run(1);
        chk("post_rst_y_count", b0.y_count, 4);
        for (int ri = 0; ri < 2; ri++) begin
            for (int rj = 0; rj < 2; rj++) rb(ri, rj, yref(ri, rj));
        end

        // Timeout instance
        b1.load_valid = 1'b1; b1.load_sel = 3'd0; b1.load_data = 10'd1;
        tick();
        b1.load_valid = 1'b0;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        chk("to_mo_reset_n", b1.mo_reset_n, 1);
        cnt = 0;
        while (!b1.done && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("to_cycles", cnt, 16);
        chk("to_flag", b1.timeout, 1);
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        chk("to_cleared", b1.timeout, 0);
        repeat (15) tick();
        chk("to_not_done", b1.done, 0);
        b1.fin = 1'b1;
        tick();
        b1.fin = 1'b0;
        chk("to_fin_done", b1.done, 1);
        chk("to_fin_wins", b1.timeout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
